div_unit: RTL

Iterative integer divide execution unit for the LEN5 execution pipeline. It sits between the divider reservation station and the common data bus arbiter, and implements RISC-V M-extension DIV/DIVU/REM/REMU plus the RV64 word forms (DIVW/DIVUW/REMW/REMUW). It uses a radix-2 restoring algorithm, a multi-cycle FSM with fast-path corner cases, and valid/ready handshakes on both sides. It replaces the single-cycle divider and adds:
- signed/unsigned selection
- remainder results
- 32-bit word mode
- corner-case semantics
- backpressure
- flush

---
 rtl/div_unit.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// ============================================================================
//  Module   : div_unit (with support package div_unit_pkg)
//  Purpose  : Iterative radix-2 restoring integer divider for the LEN5
//             execution pipeline. Executes DIV/DIVU/REM/REMU and the RV64
//             word forms. It accepts one operation at a time, flags
//             divide-by-zero and signed overflow at accept time, and has
//             valid/ready handshakes on both sides plus a synchronous flush.
//  Ports    :
//    clk_i, rst_i              clock, synchronous active-high reset
//    flush_i                   discard any in-flight or unconsumed operation
//    issue_valid_i/ready_o     operation handshake from the reservation station
//    ctl_i                     [1:0] op (DIV,DIVU,REM,REMU), [2] word mode
//    rs1_i, rs2_i              dividend, divisor
//    entry_idx_i/o             reservation station tag in / out
//    res_valid_o/ready_i       result handshake towards the CDB arbiter
//    result_o                  quotient or remainder
//    except_raised_o/code_o    constant: division never traps
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_unit_pkg;
    typedef enum logic [4:0] {
        E_INSTR_ADDR_MISALIGNED = 5'h00,
        E_INSTR_ACCESS_FAULT    = 5'h01,
        E_ILLEGAL_INSTRUCTION   = 5'h02,
        E_BREAKPOINT            = 5'h03,
        E_UNKNOWN               = 5'h1f
    } except_code_t;
endpackage

module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int RS_DEPTH   = 4,
    parameter int EU_CTL_LEN = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        flush_i,
    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  logic [EU_CTL_LEN-1:0]       ctl_i,
    input  logic [XLEN-1:0]             rs1_i,
    input  logic [XLEN-1:0]             rs2_i,
    input  logic [$clog2(RS_DEPTH)-1:0] entry_idx_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [$clog2(RS_DEPTH)-1:0] entry_idx_o,
    output logic [XLEN-1:0]             result_o,
    output logic                        except_raised_o,
    output except_code_t                except_code_o
);

    localparam int IDX_W = $clog2(RS_DEPTH);
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              issue_ready_q, issue_ready_d;
    logic              res_valid_q, res_valid_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              is_rem_q, is_rem_d;
    logic              is_w_q, is_w_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    // Shift register: dividend bits leave at the MSB while quotient bits
    // enter at the LSB, so one register serves both purposes.
    logic [XLEN-1:0]   quot_q, quot_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // ------------------------------------------------------------------
    // Operand decode and preparation (evaluated on the raw inputs)
    // ------------------------------------------------------------------
    logic            w_signed, w_is_rem, w_word;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_min_neg;
    logic            w_a_neg, w_b_neg, w_div_zero, w_ovf, w_fast;
    logic [XLEN-1:0] w_fast_raw, w_fast_res;
    logic            w_unused_ctl;

    assign w_signed = ~ctl_i[0];
    assign w_is_rem = ctl_i[1];
    assign w_word   = ctl_i[2];
    assign w_unused_ctl = ^ctl_i[EU_CTL_LEN-1:3];

    always_comb begin
        w_a_ext = rs1_i;
        w_b_ext = rs2_i;
        if (w_word) begin
            w_a_ext = {{(XLEN-32){w_signed & rs1_i[31]}}, rs1_i[31:0]};
            w_b_ext = {{(XLEN-32){w_signed & rs2_i[31]}}, rs2_i[31:0]};
        end
    end

    assign w_a_neg = w_signed & w_a_ext[XLEN-1];
    assign w_b_neg = w_signed & w_b_ext[XLEN-1];
    // The magnitude of the most-negative value is still correct when read
    // as unsigned, so no special case is needed here.
    assign w_a_mag = w_a_neg ? (~w_a_ext + 1'b1) : w_a_ext;
    assign w_b_mag = w_b_neg ? (~w_b_ext + 1'b1) : w_b_ext;

    // Most-negative value of the active width, after extension to XLEN.
    assign w_min_neg = w_word ? {{(XLEN-31){1'b1}}, {31{1'b0}}}
                              : {1'b1, {(XLEN-1){1'b0}}};

    assign w_div_zero = (w_b_ext == '0);
    assign w_ovf      = w_signed && (w_b_ext == '1) && (w_a_ext == w_min_neg);
    assign w_fast     = w_div_zero | w_ovf;

    always_comb begin
        if (w_div_zero) begin
            w_fast_raw = w_is_rem ? w_a_ext : '1;
        end else begin
            w_fast_raw = w_is_rem ? '0 : w_a_ext;
        end
        w_fast_res = w_fast_raw;
        if (w_word) begin
            w_fast_res = {{(XLEN-32){w_fast_raw[31]}}, w_fast_raw[31:0]};
        end
    end

    // ------------------------------------------------------------------
    // One restoring-division step
    // ------------------------------------------------------------------
    logic [XLEN:0]   w_rem_shift;
    logic [XLEN+1:0] w_diff;
    logic            w_q_bit;
    logic [XLEN-1:0] w_rem_next, w_quot_next;
    logic [XLEN-1:0] w_quo_fin, w_rem_fin, w_sel, w_final;

    assign w_rem_shift = {rem_q, quot_q[XLEN-1]};
    assign w_diff      = {1'b0, w_rem_shift} - {2'b00, divisor_q};
    assign w_q_bit     = ~w_diff[XLEN+1];
    // The kept partial remainder is always below the divisor, so it fits
    // in XLEN bits even though the shifted value needs one more.
    assign w_rem_next  = w_q_bit ? w_diff[XLEN-1:0] : w_rem_shift[XLEN-1:0];
    assign w_quot_next = {quot_q[XLEN-2:0], w_q_bit};

    assign w_quo_fin = neg_quo_q ? (~w_quot_next + 1'b1) : w_quot_next;
    assign w_rem_fin = neg_rem_q ? (~w_rem_next + 1'b1) : w_rem_next;
    assign w_sel     = is_rem_q ? w_rem_fin : w_quo_fin;
    assign w_final   = is_w_q ? {{(XLEN-32){w_sel[31]}}, w_sel[31:0]} : w_sel;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        issue_ready_d = issue_ready_q;
        res_valid_d   = res_valid_q;
        res_d         = res_q;
        idx_d         = idx_q;
        is_rem_d      = is_rem_q;
        is_w_d        = is_w_q;
        neg_quo_d     = neg_quo_q;
        neg_rem_d     = neg_rem_q;
        divisor_d     = divisor_q;
        quot_d        = quot_q;
        rem_d         = rem_q;
        cnt_d         = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (issue_valid_i && issue_ready_q) begin
                    idx_d         = entry_idx_i;
                    is_rem_d      = w_is_rem;
                    is_w_d        = w_word;
                    neg_quo_d     = w_a_neg ^ w_b_neg;
                    neg_rem_d     = w_a_neg;
                    divisor_d     = w_b_mag;
                    rem_d         = '0;
                    // Word mode runs 32 steps, so the dividend starts
                    // left-aligned to feed its bit 31 first.
                    quot_d        = w_word ? {w_a_mag[31:0], {(XLEN-32){1'b0}}}
                                           : w_a_mag;
                    cnt_d         = w_word ? CNT_W'(31) : CNT_W'(XLEN-1);
                    issue_ready_d = 1'b0;
                    if (w_fast) begin
                        state_d     = S_DONE;
                        res_d       = w_fast_res;
                        res_valid_d = 1'b1;
                    end else begin
                        state_d     = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                quot_d = w_quot_next;
                rem_d  = w_rem_next;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = S_DONE;
                    res_d       = w_final;
                    res_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (res_ready_i) begin
                    state_d       = S_IDLE;
                    res_valid_d   = 1'b0;
                    issue_ready_d = 1'b1;
                end
            end
            default: begin
                state_d       = S_IDLE;
                res_valid_d   = 1'b0;
                issue_ready_d = 1'b1;
            end
        endcase

        // Flush overrides any handshake in the same cycle.
        if (flush_i) begin
            state_d       = S_IDLE;
            res_valid_d   = 1'b0;
            issue_ready_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            issue_ready_q <= 1'b1;
            res_valid_q   <= 1'b0;
            res_q         <= '0;
            idx_q         <= '0;
            is_rem_q      <= 1'b0;
            is_w_q        <= 1'b0;
            neg_quo_q     <= 1'b0;
            neg_rem_q     <= 1'b0;
            divisor_q     <= '0;
            quot_q        <= '0;
            rem_q         <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            issue_ready_q <= issue_ready_d;
            res_valid_q   <= res_valid_d;
            res_q         <= res_d;
            idx_q         <= idx_d;
            is_rem_q      <= is_rem_d;
            is_w_q        <= is_w_d;
            neg_quo_q     <= neg_quo_d;
            neg_rem_q     <= neg_rem_d;
            divisor_q     <= divisor_d;
            quot_q        <= quot_d;
            rem_q         <= rem_d;
            cnt_q         <= cnt_d;
        end
    end

    assign issue_ready_o   = issue_ready_q;
    assign res_valid_o     = res_valid_q;
    assign result_o        = res_q;
    assign entry_idx_o     = idx_q;
    assign except_raised_o = 1'b0;
    assign except_code_o   = E_UNKNOWN;

endmodule

`default_nettype wire
